// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the systolic array feeder: operand
//               width, feeder state encoding and the flush-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Operand width of every PE input lane.
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4
    } feeder_state_t;

    // Cycles needed after the last beat before the far-corner PE has
    // accumulated its final product: 2N-2 hops across the array plus the
    // accumulate cycle itself.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skew_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_line
// Description : Fixed-depth register delay line used to skew one operand
//               lane of the systolic array edge.
// Revision    : 1.0 - initial release
// Ports       : i_clk     - clock
//               i_arst_n  - asynchronous active-low reset, clears all stages
//               i_d       - lane input
//               o_q       - lane input delayed by DEPTH cycles
// ============================================================================
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_pipe[s] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int s = 1; s < DEPTH; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Feeds the west (activation) and north (weight) edges of an
//               NxN output-stationary systolic array. Accepts one reduction
//               slice per beat, skews the lanes so operand pairs meet in the
//               right PE, flushes the array, flags finished results and
//               clears the accumulators after the reader acknowledges.
// Revision    : 1.0 - initial release
// Ports       : i_clk          - clock
//               i_arst_n       - asynchronous active-low reset
//               i_valid        - slice offered on i_a / i_b
//               o_ready        - slice accepted this cycle (from state)
//               i_a            - activation column, lane i = A[i][k]
//               i_b            - weight row, lane j = B[k][j]
//               o_a            - skewed west edge, lane i drives PE(i,0)
//               o_b            - skewed north edge, lane j drives PE(0,j)
//               o_doProcess    - accumulate enable to every PE; low clears
//               o_result_valid - all PE sums are final
//               i_result_ack   - reader has captured the results
// ============================================================================
module systolic_feeder #(
    parameter int N      = 4,
    parameter int K      = 4,
    parameter int DATA_W = systolic_pkg::DATA_W
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [N*DATA_W-1:0] i_a,
    input  logic [N*DATA_W-1:0] i_b,
    output logic [N*DATA_W-1:0] o_a,
    output logic [N*DATA_W-1:0] o_b,
    output logic                o_doProcess,
    output logic                o_result_valid,
    input  logic                i_result_ack
);

    import systolic_pkg::*;

    localparam int c_CNT_W     = $clog2(K + 1);
    localparam int c_FLUSH_LEN = flush_len(N);
    localparam int c_FL_W      = $clog2(c_FLUSH_LEN + 1);

    localparam logic [c_CNT_W-1:0] c_BEATS      = c_CNT_W'(K);
    localparam logic [c_CNT_W-1:0] c_BEAT_ONE   = c_CNT_W'(1);
    localparam logic [c_FL_W-1:0]  c_FLUSH_LAST = c_FL_W'(c_FLUSH_LEN - 1);
    localparam logic [c_FL_W-1:0]  c_FL_ONE     = c_FL_W'(1);

    feeder_state_t        r_state;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic [c_FL_W-1:0]    r_flush_cnt;
    logic                 r_do_process;
    logic                 r_result_valid;

    logic                 w_xfer;
    logic [c_CNT_W-1:0]   w_beat_next;
    logic [N*DATA_W-1:0]  w_a_in;
    logic [N*DATA_W-1:0]  w_b_in;

    assign o_ready     = (r_state == IDLE) ||
                         ((r_state == LOAD) && (r_beat_cnt < c_BEATS));
    assign w_xfer      = i_valid && o_ready;
    assign w_beat_next = r_beat_cnt + c_BEAT_ONE;

    // Any cycle without a transfer (bubble, flush, hold) injects zeros, which
    // keeps later slices aligned and contributes nothing to the sums.
    assign w_a_in = w_xfer ? i_a : '0;
    assign w_b_in = w_xfer ? i_b : '0;

    // Lane g is delayed 1+g cycles so that A[i][k] and B[k][j] reach PE(i,j)
    // on the same cycle after i+j hops inside the array.
    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_line #(
            .DEPTH (g + 1),
            .WIDTH (DATA_W)
        ) u_skew_a (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .i_d      (w_a_in[g*DATA_W +: DATA_W]),
            .o_q      (o_a[g*DATA_W +: DATA_W])
        );

        skew_line #(
            .DEPTH (g + 1),
            .WIDTH (DATA_W)
        ) u_skew_b (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .i_d      (w_b_in[g*DATA_W +: DATA_W]),
            .o_q      (o_b[g*DATA_W +: DATA_W])
        );
    end

    // Job sequencer. IDLE and LOAD share the beat handling; with K=1 the
    // first beat is also the last and goes straight to FLUSH.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state        <= IDLE;
            r_beat_cnt     <= '0;
            r_flush_cnt    <= '0;
            r_do_process   <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, LOAD: begin
                    if (w_xfer) begin
                        r_beat_cnt   <= w_beat_next;
                        r_do_process <= 1'b1;
                        r_flush_cnt  <= '0;
                        if (w_beat_next == c_BEATS) begin
                            r_state <= FLUSH;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_state        <= HOLD;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_FL_ONE;
                    end
                end
                HOLD: begin
                    // Accumulation stays enabled; the edges carry zeros so
                    // the sums are stable until the reader acknowledges.
                    if (i_result_ack) begin
                        r_state        <= CLEAR;
                        r_result_valid <= 1'b0;
                        r_do_process   <= 1'b0;
                    end
                end
                CLEAR: begin
                    // The single low enable cycle zeroes every accumulator.
                    r_state    <= IDLE;
                    r_beat_cnt <= '0;
                end
                default: begin
                    r_state        <= IDLE;
                    r_beat_cnt     <= '0;
                    r_flush_cnt    <= '0;
                    r_do_process   <= 1'b0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_doProcess    = r_do_process;
    assign o_result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
# systolic_feeder

Drives the west (activation) and north (weight) edges of an N×N output-stationary systolic array of 8-bit MAC processing elements. It accepts one reduction slice per handshake beat and applies the diagonal skew so that operand pairs meet in the correct PE. It flushes the array, flags when every PE holds its final sum, and clears the accumulators once the downstream result reader acknowledges. It sits between the image/weight buffers and the array, and is the transmit side of the PE operand interface.

## Interface
- `N`, default 4: array dimension; number of rows and columns.
- `K`, default 4: reduction length; number of beats per job.
- `DATA_W`, default 8: operand width; taken from the package.
- `i_clk`, input, 1: the single clock.
- `i_arst_n`, input, 1: reset. Asynchronous assert, active-low.
- `i_valid`, input, 1: a slice is offered on `i_a`/`i_b`.
- `o_ready`, output, 1: the feeder accepts a slice this cycle.
- `i_a`, input, N×DATA_W: activation column A[0..N-1][k].
- `i_b`, input, N×DATA_W: weight row B[k][0..N-1].
- `o_a`, output, N×DATA_W: skewed west-edge operands; row i drives PE(i,0).
- `o_b`, output, N×DATA_W: skewed north-edge operands; column j drives PE(0,j).
- `o_doProcess`, output, 1: process/accumulate enable, broadcast to every PE.
- `o_result_valid`, output, 1: all N² PE outputs hold the finished C = A·B.
- `i_result_ack`, input, 1: the reader has captured the results.

## Operation
- Handshake: a beat transfers when `i_valid && o_ready`. `o_ready` is combinational from state: 1 in IDLE and in LOAD while the beat count is below K, otherwise 0.
- Skew: lane i of `o_a` and lane j of `o_b` pass through 1+i and 1+j register stages respectively. A[i][k] and B[k][j] therefore meet at PE(i,j) on the same cycle.
- Bubbles: a cycle with no transfer in LOAD pushes an all-zero slice into every lane. This preserves alignment and adds nothing to the sums.
- Beat counter: width clog2(K+1). It increments only on transfer.
- Flush counter: counts 2N-1 cycles after the last beat. This covers 2N-2 propagation stages plus 1 accumulate cycle. Zeros are injected throughout the flush.
- FSM states and transitions:
  - IDLE → LOAD on the first transfer.
  - LOAD → FLUSH on the transfer that makes the count K.
  - FLUSH → HOLD when the flush counter expires.
  - HOLD → CLEAR on `i_result_ack`.
  - CLEAR → IDLE unconditionally.
- `o_doProcess`: 0 in IDLE and CLEAR, 1 in LOAD, FLUSH and HOLD. The single low cycle in CLEAR zeroes the PE accumulators.
- HOLD: the edges are driven with 0, so the products are 0 and the sums stay stable. `o_result_valid` is 1 only in HOLD.
- `i_result_ack` outside HOLD is ignored.
- K=1 and N=1 are legal. With N=1 there is no skew beyond one stage, and the flush lasts 1 cycle.

## Timing
- Reset values: `o_a`, `o_b`, `o_doProcess` and `o_result_valid` are 0, the state is IDLE, and `o_ready` is 1. All skew registers and counters are cleared.
- Reset asserted mid-job aborts the job immediately, with no partial result flagged.
- `o_doProcess` rises on the cycle after the first transfer. This is the same cycle the first slice appears on `o_a[0]`/`o_b[0]`.
- A beat transferred at cycle c appears on `o_a[i]` at c+1+i and on `o_b[j]` at c+1+j.
- With the last beat at cycle c, `o_result_valid` rises at c+2N and holds until the cycle after ack.
- When ack is sampled at cycle h: CLEAR occurs at h+1, IDLE and `o_ready`=1 at h+2. A new job's first transfer is accepted at h+2 or later.

## Structure
- `systolic_pkg` holds:
  - `DATA_W` = 8;
  - the state enum `feeder_state_t` {IDLE, LOAD, FLUSH, HOLD, CLEAR};
  - a helper function for the flush length, 2N-1.
- Sub-module `skew_line`: parameterised delay line with DEPTH and width, async active-low reset. It is instantiated once per lane, 2N instances in total.
- The top level holds the FSM, counters and handshake.

## Test plan
- Basic job, N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Beats are at cycles 0 and 1: beat 0 a={1,3}, b={5,6}; beat 1 a={2,4}, b={7,8}. Required: the array model yields C=[[19,22],[43,50]], and `o_result_valid` rises at cycle 5.
- Skew check, N=4: a single beat with a={1,2,3,4}, b={5,6,7,8}. Required: `o_a[i]` is nonzero only at cycle 1+i, and `o_b[j]` only at cycle 1+j.
- Bubbles: repeat the basic job with `i_valid` low for 3 cycles between the beats. Required: identical C, with `o_result_valid` delayed by 3 cycles.
- Backpressure and ack: hold `i_valid` high after K beats. Required: `o_ready` stays 0 through FLUSH and HOLD. Ack after 10 HOLD cycles gives `o_doProcess`=0 for exactly one cycle, then `o_ready`=1. Ack pulsed during FLUSH is ignored.
- Reset mid-FLUSH: drive `i_arst_n` low for 1 cycle. Required: all outputs take their reset values asynchronously, the state is IDLE, and no `o_result_valid` follows.
- Back-to-back jobs: the second job starts at the first cycle `o_ready` returns. Required: the second C contains no residue from the first job.
